// File: rtl/fifo_rd_drain_if.sv
// Signal bundle between the FIFO read port, the drain controller and the serial transmitter.
// master = drain controller, slave = FIFO/transmitter environment.
interface fifo_rd_drain_if #(
  parameter int D_SIZE = 8,
  parameter int CNT_W  = 16
);
  logic              i_en;
  logic              i_empty;
  logic [D_SIZE-1:0] i_r_data;
  logic              i_tx_busy;
  logic              o_r_inc;
  logic [D_SIZE-1:0] o_tx_data;
  logic              o_tx_valid;
  logic              o_busy;
  logic              o_drop;
  logic [CNT_W-1:0]  o_word_cnt;

  modport master (
    input  i_en, i_empty, i_r_data, i_tx_busy,
    output o_r_inc, o_tx_data, o_tx_valid, o_busy, o_drop, o_word_cnt
  );

  modport slave (
    output i_en, i_empty, i_r_data, i_tx_busy,
    input  o_r_inc, o_tx_data, o_tx_valid, o_busy, o_drop, o_word_cnt
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// Read-side FIFO consumer: pops one word at a time and hands it to a busy-flagged
// transmitter with handshake timeout, inter-frame gap and a delivered-word counter.
module fifo_rd_drain #(
  parameter int D_SIZE  = 8,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200,
  parameter int GAP     = 2,
  parameter int CNT_W   = 16
) (
  input logic             i_r_clk,
  input logic             i_r_rstn,
  fifo_rd_drain_if.master bus
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  // IDLE wait for work | POP strobe FIFO | SEND offer word | WAIT busy high | GAP frame spacing
  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_SEND,
    S_WAIT,
    S_GAP
  } state_t;

  state_t            r_state;
  logic [TO_W-1:0]   r_to_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_r_inc;
  logic [D_SIZE-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_busy;
  logic              r_drop;
  logic [CNT_W-1:0]  r_word_cnt;

  always_ff @(posedge i_r_clk) begin
    if (!i_r_rstn) begin
      r_state    <= S_IDLE;
      r_to_cnt   <= '0;
      r_gap_cnt  <= '0;
      r_r_inc    <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_drop     <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_r_inc <= 1'b0;
      r_drop  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_en && !bus.i_empty) begin
            r_state <= S_POP;
            r_r_inc <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_POP: begin
          r_tx_data  <= bus.i_r_data;
          r_tx_valid <= 1'b1;
          r_to_cnt   <= '0;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          // An acknowledge on the final timeout cycle still counts as delivered.
          if (bus.i_tx_busy) begin
            r_state    <= S_WAIT;
            r_tx_valid <= 1'b0;
            r_to_cnt   <= '0;
            r_word_cnt <= r_word_cnt + 1'b1;
          end else if (r_to_cnt == TO_LAST) begin
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b1;
            r_to_cnt   <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (!bus.i_tx_busy) begin
            if (GAP > 0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_r_inc    = r_r_inc;
  assign bus.o_tx_data  = r_tx_data;
  assign bus.o_tx_valid = r_tx_valid;
  assign bus.o_busy     = r_busy;
  assign bus.o_drop     = r_drop;
  assign bus.o_word_cnt = r_word_cnt;

endmodule
